// File: rtl/register_slice_pkg.sv
// Shared types for the valid/ready register slice: FSM state encoding.
package register_slice_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        BUSY  = ST_BUSY,
        FULL  = ST_FULL
    } register_slice_state_t;

endpackage

// File: rtl/register_en_async_rst.sv
// Enable-gated data register with active-high asynchronous reset.
module register_en_async_rst #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= RESET_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/register_slice_async_rst.sv
// Two-entry skid-buffer register slice; s_ready, m_valid and m_data all come from flops.
// Define REGISTER_SLICE_DATA_RST_EN to give the main/skid data registers a reset to RESET_VAL.
module register_slice_async_rst
    import register_slice_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    register_slice_state_t state_q, state_d;
    logic                  s_ready_q, m_valid_q;
    logic                  s_fire, m_fire;
    logic                  main_en, skid_en, main_from_skid;
    logic [WIDTH-1:0]      main_d, skid_q;
    logic                  data_rst;

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign s_fire  = s_valid & s_ready_q;
    assign m_fire  = m_valid_q & m_ready;

    // Handshake flags are derived from the next state so they stay registered
    // yet track the state exactly; s_ready_q resets low, so it rises one edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= (state_d != FULL);
            m_valid_q <= (state_d != EMPTY);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (s_fire) state_d = BUSY;
            BUSY: begin
                if (s_fire && !m_ready)
                    state_d = FULL;
                else if (!s_fire && m_fire)
                    state_d = EMPTY;
            end
            FULL:    if (m_fire) state_d = BUSY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: main_en = s_fire;
            BUSY: begin
                main_en = s_fire & m_ready;
                skid_en = s_fire & ~m_ready;
            end
            FULL: begin
                main_en        = m_fire;
                main_from_skid = 1'b1;
            end
            default: ;
        endcase
    end

    assign main_d = main_from_skid ? skid_q : s_data;

`ifdef REGISTER_SLICE_DATA_RST_EN
    assign data_rst = rst;
`else
    assign data_rst = 1'b0;
`endif

    register_en_async_rst #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk (clk),
        .rst (data_rst),
        .en  (main_en),
        .d   (main_d),
        .q   (m_data)
    );

    register_en_async_rst #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk (clk),
        .rst (data_rst),
        .en  (skid_en),
        .d   (s_data),
        .q   (skid_q)
    );

endmodule

// File: tb/tb_register_slice_async_rst.sv
// Scoreboard bench for register_slice_async_rst: directed reset/stream/stall/single-beat plus random traffic.
module tb_register_slice_async_rst;

    localparam int         W  = 8;
    localparam logic [W-1:0] RV = 8'h3C;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    register_slice_async_rst #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Stimulus side of the scoreboard: record every payload the slice accepts.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && s_valid && s_ready)
                exp_q.push_back(s_data);
        end
    end

    // Monitor: pop on each downstream transfer and enforce stall stability.
    initial begin
        logic         stall;
        logic [W-1:0] stall_data;
        stall = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", 32'(m_data), 32'(stall_data));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none at %0t", m_data, $time);
                end else begin
                    chk("order", 32'(m_data), 32'(exp_q.pop_front()));
                end
            end
            stall      = m_valid && !m_ready;
            stall_data = m_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (2) edge1();
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        rst = 1'b0;
        chk("rel_s_ready_pre", 32'(s_ready), 32'd0);
        edge1();
        chk("rel_s_ready", 32'(s_ready), 32'd1);
        chk("rel_m_valid", 32'(m_valid), 32'd0);

        // Streaming: one beat per cycle, data one cycle delayed.
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = W'(i);
            edge1();
            chk("stream_valid", 32'(m_valid), 32'd1);
            chk("stream_ready", 32'(s_ready), 32'd1);
            chk("stream_data", 32'(m_data), 32'(i));
        end
        s_valid = 1'b0;
        edge1();
        chk("stream_end_valid", 32'(m_valid), 32'd0);

        // Stall: 0xA then 0xB against m_ready=0 fills both entries.
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h0A;
        edge1();
        s_data  = 8'h0B;
        edge1();
        s_valid = 1'b0;
        chk("full_ready", 32'(s_ready), 32'd0);
        chk("full_valid", 32'(m_valid), 32'd1);
        chk("full_data", 32'(m_data), 32'h0A);
        edge1();
        chk("full_hold_ready", 32'(s_ready), 32'd0);
        chk("full_hold_data", 32'(m_data), 32'h0A);
        m_ready = 1'b1;
        edge1();
        chk("drain_data_b", 32'(m_data), 32'h0B);
        chk("drain_ready", 32'(s_ready), 32'd1);
        edge1();
        chk("drain_empty", 32'(m_valid), 32'd0);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);

        // Single beat.
        s_valid = 1'b1;
        s_data  = 8'h05;
        edge1();
        s_valid = 1'b0;
        chk("beat_valid", 32'(m_valid), 32'd1);
        chk("beat_data", 32'(m_data), 32'h05);
        edge1();
        chk("beat_gone", 32'(m_valid), 32'd0);
        chk("beat_ready", 32'(s_ready), 32'd1);
        edge1();
        chk("beat_stays_empty", 32'(m_valid), 32'd0);

        // Reset while FULL: in-flight payloads are discarded.
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hC1;
        edge1();
        s_data  = 8'hD2;
        edge1();
        s_valid = 1'b0;
        chk("pre_rst_full", 32'(s_ready), 32'd0);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("async_rst_m_valid", 32'(m_valid), 32'd0);
        chk("async_rst_s_ready", 32'(s_ready), 32'd0);
`ifdef REGISTER_SLICE_DATA_RST_EN
        chk("async_rst_m_data", 32'(m_data), 32'(RV));
`endif
        edge1();
        rst = 1'b0;
        chk("rel2_s_ready_pre", 32'(s_ready), 32'd0);
        edge1();
        chk("rel2_s_ready", 32'(s_ready), 32'd1);
        chk("rel2_m_valid", 32'(m_valid), 32'd0);
`ifdef REGISTER_SLICE_DATA_RST_EN
        chk("rel2_m_data", 32'(m_data), 32'(RV));
`endif
        m_ready = 1'b1;
        edge1();
        chk("rel2_discarded", 32'(m_valid), 32'd0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = W'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            edge1();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (4) edge1();
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("rand_end_valid", 32'(m_valid), 32'd0);
        chk("rand_end_ready", 32'(s_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
